// File: rtl/minterm_sweeper.sv
// minterm_sweeper
// Recovers the truth table of an N_IN-input combinational function. It steps
// abcd_out through every code, waits SETTLE cycles for the network to settle,
// samples f_in and builds a minterm mask (bit i = f(i)) and a population count.
// At the end of the sweep the mask is compared against a golden mask.
module minterm_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 f_in,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      abcd_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   minterms,
  output logic [N_IN:0]        minterm_count,
  output logic                 match
);

  localparam int MASK_W = 2 ** N_IN;
  localparam int CNT_W  = N_IN + 1;
  // The wait counter only needs to reach SETTLE-1; keep at least one bit.
  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [N_IN-1:0]   LAST_IDX  = N_IN'(MASK_W - 1);
  localparam logic [N_IN-1:0]   IDX_ONE   = N_IN'(32'd1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(SETTLE - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [N_IN-1:0]     idx_r;
  logic [WAIT_W-1:0]   wait_r;
  logic [N_IN-1:0]     abcd_r;
  logic [MASK_W-1:0]   minterms_r;
  logic [CNT_W-1:0]    count_r;
  logic                match_r;

  logic                settle_end_s;
  logic                last_vec_s;
  logic [MASK_W-1:0]   final_mask_s;

  // Complete mask as it will look after the last sample: the top bit comes
  // straight from f_in because it is being written in the same cycle.
  function automatic logic [MASK_W-1:0] close_mask(
    input logic              top_bit,
    input logic [MASK_W-1:0] mask
  );
    return {top_bit, mask[MASK_W-2:0]};
  endfunction

  // Decode of the settle and sweep-end conditions shared by FSM and datapath.
  always_comb begin
    settle_end_s = 1'b0;
    last_vec_s   = 1'b0;
    final_mask_s = close_mask(f_in, minterms_r);
    if (wait_r == LAST_WAIT) begin
      settle_end_s = 1'b1;
    end else begin
      settle_end_s = 1'b0;
    end
    if (idx_r == LAST_IDX) begin
      last_vec_s = 1'b1;
    end else begin
      last_vec_s = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: IDLE -> (SETTLE -> SAMPLE) x 2^N_IN -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_end_s) begin
          state_nxt_s = ST_SAMPLE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (last_vec_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      ST_SETTLE, ST_SAMPLE: begin
        busy = 1'b1;
        done = 1'b0;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Sweep datapath: vector index, settle counter, mask, count and match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r      <= '0;
      wait_r     <= '0;
      abcd_r     <= '0;
      minterms_r <= '0;
      count_r    <= '0;
      match_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A new sweep clears the previous results; otherwise they persist.
          if (start) begin
            idx_r      <= '0;
            wait_r     <= '0;
            abcd_r     <= '0;
            minterms_r <= '0;
            count_r    <= '0;
            match_r    <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!settle_end_s) begin
            wait_r <= wait_r + WAIT_ONE;
          end
        end
        ST_SAMPLE: begin
          minterms_r[idx_r] <= f_in;
          count_r           <= count_r + CNT_W'(f_in);
          if (last_vec_s) begin
            // expected is only looked at here, on the final sample.
            match_r <= (final_mask_s == expected);
          end else begin
            idx_r  <= idx_r + IDX_ONE;
            abcd_r <= idx_r + IDX_ONE;
            wait_r <= '0;
          end
        end
        ST_DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign abcd_out      = abcd_r;
  assign minterms      = minterms_r;
  assign minterm_count = count_r;
  assign match         = match_r;

endmodule
